seq_cla_addsub: RTL and testbench
=================================

Name: seq_cla_addsub

Overview:
- Parametrised, multi-cycle carry-lookahead adder/subtractor for the stack-CPU ALU datapath.
- It uses one CHUNK-bit lookahead slice per cycle and registers the carry between slices. This trades latency for area at wide WIDTH.
- It supports ADD, ADC, SUB and SBB, and produces carry, overflow, zero and negative flags.
- Operands enter and results leave through valid/ready handshakes, so the block can sit between the stack-read and write-back stages.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits processed per cycle; derived NCHUNK = WIDTH/CHUNK (>= 1).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand request valid
in_ready  out  1  block can accept a request (high only in IDLE)
op  in  2  00 ADD, 01 ADC, 10 SUB, 11 SBB
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in for ADC/SBB; ignored for ADD/SUB
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result
cout  out  1  carry out of MSB (SUB/SBB: 1 = no borrow)
overflow  out  1  signed overflow
zero  out  1  sum == 0
negative  out  1  sum[WIDTH-1]

Behaviour:
- Reset: asynchronous and active-high, one clock; the reset condition takes effect immediately without waiting for clk.
  - State goes to IDLE and the chunk index to 0.
  - sum, cout, overflow, zero, negative and out_valid go to 0; in_ready goes to 1.
  - Any in-flight operation is discarded with no partial output.
- Operand conditioning at accept: effective B = b for ADD/ADC, ~b for SUB/SBB. Initial carry:
  - ADD = 0
  - ADC = cin
  - SUB = 1
  - SBB = cin (carry convention: cin=1 means no borrow pending)
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid at a clk edge: latch a, effective B, initial carry and op; clear the sum register; idx=0; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle, slice idx of A and B plus the carry register feed the lookahead slice. The slice sum is written to sum[idx*CHUNK +: CHUNK] and the carry register takes the slice carry-out.
  - On the final slice (idx == NCHUNK-1):
    - cout = slice carry-out.
    - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
    - zero and negative are computed from the completed sum.
    - State goes to DONE.
  - Otherwise idx increments.
- DONE:
  - out_valid=1 and all outputs are held stable while out_ready=0.
  - On out_ready=1 at a clk edge, go to IDLE; out_valid drops the next cycle. Outputs keep their last value and are only meaningful with out_valid.
- Latency: a request accepted at edge T produces out_valid high after edge T+NCHUNK.
  - Minimum issue interval is NCHUNK+2 cycles: there is no accept in DONE.
  - NCHUNK=1 gives a single RUN cycle.
- Arithmetic is modulo 2^WIDTH. There is no saturation and no X propagation: all registers are reset.
- op, cin, a and b are sampled only at accept; later changes have no effect.

Decomposition:
- Shared package alu_pkg:
  - op encodings: ALU_OP_ADD, ALU_OP_ADC, ALU_OP_SUB, ALU_OP_SBB.
  - FSM state encoding: ST_IDLE, ST_RUN, ST_DONE.
- One sub-module, cla_slice, parametrised by CHUNK. It is combinational lookahead over CHUNK bits with outputs:
  - slice sum
  - carry-out
  - carry into the slice MSB (for overflow)
  - group generate/propagate
- seq_cla_addsub holds the FSM, operand and carry registers, chunk index and flag logic.

Test Plan:
- ADD, WIDTH=16/CHUNK=4: a=0x7FFF, b=0x0001 -> sum 0x8000, cout 0, overflow 1, negative 1, zero 0; out_valid exactly 4 cycles after accept.
- SUB: a=0x0005, b=0x0005 -> sum 0x0000, cout 1, zero 1, overflow 0. Then SUB a=0x0000, b=0x0001 -> sum 0xFFFF, cout 0, negative 1, overflow 0.
- ADC full ripple: a=0xFFFF, b=0x0000, cin=1 -> sum 0x0000, cout 1, zero 1, overflow 0. Same op with ADD ignores cin -> sum 0xFFFF, cout 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready 0, in_valid pulses ignored. Then out_ready=1 -> IDLE next cycle, and the next op is accepted and computed correctly.
- Reset mid-op: assert rst during the 2nd RUN cycle -> out_valid 0, in_ready 1 and flags 0 without waiting for clk. After release, SBB a=0x8000, b=0x0001, cin=1 -> sum 0x7FFF, overflow 1, cout 1.
- Parameter sweep: CHUNK=16 (NCHUNK=1) gives latency 1. WIDTH=32/CHUNK=8 gives latency 4. Random ops are checked against a reference model (2000 vectors per configuration).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings: operation codes, sequencer states, and the operand-conditioning helpers
// that map each operation to its initial carry and its B-inversion.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_OP_ADD = 2'b00,
    ALU_OP_ADC = 2'b01,
    ALU_OP_SUB = 2'b10,
    ALU_OP_SBB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Carry convention for SBB: cin=1 means no borrow pending.
  function automatic logic init_carry(input alu_op_e op, input logic cin);
    case (op)
      ALU_OP_ADD: return 1'b0;
      ALU_OP_SUB: return 1'b1;
      default:    return cin;
    endcase
  endfunction

  function automatic logic is_sub(input alu_op_e op);
    return (op == ALU_OP_SUB) || (op == ALU_OP_SBB);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// CHUNK-bit combinational carry-lookahead adder slice; zero latency, no flow control.
// Exposes the carry into the MSB for overflow and the group generate/propagate terms.
module cla_slice
  import alu_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb,
  output logic             g,
  output logic             p
);

  logic [CHUNK-1:0] gbit, pbit, c;
  logic             term, pp;

  always_comb begin
    gbit = a & b;
    pbit = a ^ b;
    c    = '0;
    term = 1'b0;
    pp   = 1'b1;
    // c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]ci, expanded without a ripple chain
    for (int i = 0; i < CHUNK; i++) begin
      term = 1'b0;
      pp   = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (gbit[j] & pp);
        pp   = pp & pbit[j];
      end
      c[i] = term | (ci & pp);
    end
    term = 1'b0;
    pp   = 1'b1;
    for (int j = CHUNK - 1; j >= 0; j--) begin
      term = term | (gbit[j] & pp);
      pp   = pp & pbit[j];
    end
    g = term;
    p = pp;
  end

  assign s     = pbit ^ c;
  assign co    = g | (p & ci);
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_cla_addsub.sv
// Multi-cycle add/sub: one CHUNK-bit lookahead slice per cycle, result valid NCHUNK cycles after accept.
// in_ready only in IDLE; result and flags are held in DONE until out_ready.
module seq_cla_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  alu_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic             carry_q;
  logic             cout_q, ovf_q, zero_q, neg_q;
  logic [CHUNK-1:0] sl_a, sl_b, sl_s;
  logic             sl_co, sl_cmsb, sl_g, sl_p;
  logic             last;

  assign last = (idx_q == LAST);

  always_comb begin
    sl_a  = a_q[int'(idx_q)*CHUNK +: CHUNK];
    sl_b  = b_q[int'(idx_q)*CHUNK +: CHUNK];
    sum_d = sum_q;
    sum_d[int'(idx_q)*CHUNK +: CHUNK] = sl_s;
  end

  cla_slice #(.CHUNK(CHUNK)) u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .ci    (carry_q),
    .s     (sl_s),
    .co    (sl_co),
    .c_msb (sl_cmsb),
    .g     (sl_g),
    .p     (sl_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= is_sub(alu_op_e'(op)) ? ~b : b;
            carry_q <= init_carry(alu_op_e'(op), cin);
            sum_q   <= '0;
            idx_q   <= '0;
          end
        end
        ST_RUN: begin
          sum_q   <= sum_d;
          carry_q <= sl_co;
          if (last) begin
            // final carry taken from the group terms; overflow from carries around the MSB
            cout_q <= sl_g | (sl_p & carry_q);
            ovf_q  <= sl_cmsb ^ sl_co;
            zero_q <= (sum_d == '0);
            neg_q  <= sum_d[WIDTH-1];
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;

endmodule

// File: tb/tb_seq_cla_addsub.sv
// Bench for seq_cla_addsub: three configurations (16/4, 16/16, 32/8) share one stimulus stream
// and are checked every cycle against an arithmetic reference, plus directed literal checks.
module tb_seq_cla_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, out_ready, cin_s;
  logic [1:0]  op_s;
  logic [31:0] a_s, b_s;

  logic        ir0, ov0, co0, of0, z0, n0;
  logic [15:0] s0;
  logic        ir1, ov1, co1, of1, z1, n1;
  logic [15:0] s1;
  logic        ir2, ov2, co2, of2, z2, n2;
  logic [31:0] s2;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          acc_cnt[3];
  int          done_cnt[3];
  int          acc_cyc[3];
  bit          seen[3];
  logic [35:0] exp_res[3];

  always #5 clk = ~clk;

  seq_cla_addsub #(.WIDTH(16), .CHUNK(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .op(op_s),
    .a(a_s[15:0]), .b(b_s[15:0]), .cin(cin_s), .out_valid(ov0), .out_ready(out_ready),
    .sum(s0), .cout(co0), .overflow(of0), .zero(z0), .negative(n0));

  seq_cla_addsub #(.WIDTH(16), .CHUNK(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .op(op_s),
    .a(a_s[15:0]), .b(b_s[15:0]), .cin(cin_s), .out_valid(ov1), .out_ready(out_ready),
    .sum(s1), .cout(co1), .overflow(of1), .zero(z1), .negative(n1));

  seq_cla_addsub #(.WIDTH(32), .CHUNK(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .op(op_s),
    .a(a_s), .b(b_s), .cin(cin_s), .out_valid(ov2), .out_ready(out_ready),
    .sum(s2), .cout(co2), .overflow(of2), .zero(z2), .negative(n2));

  function automatic int wid(input int k);
    return (k == 2) ? 32 : 16;
  endfunction

  function automatic int lat(input int k);
    return (k == 1) ? 1 : 4;
  endfunction

  // Reference: plain modular arithmetic, signed overflow from operand/result signs.
  function automatic logic [35:0] model(input int w, input logic [1:0] op,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    logic [32:0] mask, am, bm, full;
    logic [31:0] s;
    logic        c0, sa, sb, ss;
    mask = (33'd1 << w) - 33'd1;
    am   = {1'b0, a} & mask;
    bm   = (op[1] ? ~{1'b0, b} : {1'b0, b}) & mask;
    c0   = (op == 2'b00) ? 1'b0 : (op == 2'b10) ? 1'b1 : cin;
    full = am + bm + {32'd0, c0};
    s    = full[31:0] & mask[31:0];
    sa   = am[w-1];
    sb   = bm[w-1];
    ss   = s[w-1];
    return {s, full[w], (sa == sb) && (ss != sa), s == 32'd0, ss};
  endfunction

  task automatic chk(input string nm, input logic [35:0] got, input logic [35:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, expv);
    end
  endtask

  function automatic bit all_done();
    return (acc_cnt[0] == done_cnt[0]) && (acc_cnt[1] == done_cnt[1]) &&
           (acc_cnt[2] == done_cnt[2]);
  endfunction

  task automatic cmp(input int k, input logic ov, input logic ir, input logic [31:0] s,
                     input logic co, input logic of, input logic z, input logic n);
    bit pend;
    if (rst) begin
      done_cnt[k] = acc_cnt[k];
      seen[k]     = 1'b0;
      return;
    end
    pend = (acc_cnt[k] != done_cnt[k]);
    if (ov) begin
      if (!pend) begin
        chk($sformatf("u%0d_spurious_valid", k), 36'(ov), 36'd0);
      end else begin
        if (!seen[k]) begin
          chk($sformatf("u%0d_latency", k), 36'(cyc - acc_cyc[k] - 1), 36'(lat(k)));
          seen[k] = 1'b1;
        end
        chk($sformatf("u%0d_result", k), {s, co, of, z, n}, exp_res[k]);
        chk($sformatf("u%0d_in_ready_busy", k), 36'(ir), 36'd0);
        if (out_ready) begin
          done_cnt[k]++;
          seen[k] = 1'b0;
        end
      end
    end else begin
      chk($sformatf("u%0d_in_ready", k), 36'(ir), 36'(!pend));
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    cmp(0, ov0, ir0, {16'h0, s0}, co0, of0, z0, n0);
    cmp(1, ov1, ir1, {16'h0, s1}, co1, of1, z1, n1);
    cmp(2, ov2, ir2, s2, co2, of2, z2, n2);
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!(ir0 && ir1 && ir2) && t < 100);
    if (!(ir0 && ir1 && ir2)) begin
      chk("issue_timeout", 36'({ir0, ir1, ir2}), 36'h7);
      return;
    end
    op_s = op; a_s = a; b_s = b; cin_s = c; in_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_res[k] = model(wid(k), op, a, b, c);
      acc_cyc[k] = cyc;
      acc_cnt[k]++;
    end
    #1;
    in_valid = 1'b0;
    a_s = $urandom; b_s = $urandom; op_s = 2'($urandom); cin_s = 1'($urandom);
  endtask

  task automatic wait_ov0();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ov0 && t < 50);
    if (!ov0) chk("ov0_timeout", 36'(ov0), 36'd1);
  endtask

  task automatic drain(input bit rnd);
    int t;
    t = 0;
    while (!all_done() && t < 200) begin
      @(posedge clk);
      #1;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      t++;
    end
    if (!all_done()) chk("drain_timeout", 36'({ov0, ov1, ov2}), 36'd0);
    out_ready = 1'b1;
  endtask

  task automatic dchk(input string nm, input logic [15:0] es, input logic ec,
                      input logic eo, input logic ez, input logic en);
    chk({nm, "_sum"}, 36'(s0), 36'(es));
    chk({nm, "_cout"}, 36'(co0), 36'(ec));
    chk({nm, "_overflow"}, 36'(of0), 36'(eo));
    chk({nm, "_zero"}, 36'(z0), 36'(ez));
    chk({nm, "_negative"}, 36'(n0), 36'(en));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    in_valid = 1'b0; out_ready = 1'b1; op_s = 2'b00; a_s = '0; b_s = '0; cin_s = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 36'(ov0), 36'd0);
    chk("rst_in_ready", 36'(ir0), 36'd1);
    dchk("rst", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    chk("model_sbb", model(16, 2'b11, 32'h8000, 32'h1, 1'b1), {32'h7FFF, 4'b1100});
    chk("model_sub32", model(32, 2'b10, 32'h0, 32'h1, 1'b0), {32'hFFFF_FFFF, 4'b0001});
    chk("model_adc", model(16, 2'b01, 32'hFFFF, 32'h0, 1'b1), {32'h0, 4'b1010});

    issue(2'b00, 32'h7FFF, 32'h0001, 1'b0);
    repeat (4) @(negedge clk);
    chk("add_latency_early", 36'(ov0), 36'd0);
    @(negedge clk);
    chk("add_latency", 36'(ov0), 36'd1);
    dchk("add", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);

    issue(2'b10, 32'h0005, 32'h0005, 1'b0);
    wait_ov0();
    dchk("sub_eq", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(2'b10, 32'h0000, 32'h0001, 1'b0);
    wait_ov0();
    dchk("sub_neg", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);

    issue(2'b01, 32'hFFFF, 32'h0000, 1'b1);
    wait_ov0();
    dchk("adc_ripple", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(2'b00, 32'hFFFF, 32'h0000, 1'b1);
    wait_ov0();
    dchk("add_nocin", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);

    @(posedge clk); #1 out_ready = 1'b0;
    issue(2'b00, 32'h1234, 32'h1111, 1'b0);
    wait_ov0();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a_s = $urandom; b_s = $urandom; op_s = 2'($urandom);
      @(negedge clk);
      chk("bp_hold_valid", 36'(ov0), 36'd1);
      chk("bp_hold_in_ready", 36'(ir0), 36'd0);
      dchk("bp_hold", 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_valid", 36'(ov0), 36'd0);
    chk("bp_release_in_ready", 36'(ir0), 36'd1);
    issue(2'b10, 32'h0100, 32'h0001, 1'b0);
    wait_ov0();
    dchk("bp_next", 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0);

    issue(2'b00, 32'h00F0, 32'h0F0F, 1'b0);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 36'(ov0), 36'd0);
    chk("rst_mid_in_ready", 36'(ir0), 36'd1);
    dchk("rst_mid", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    issue(2'b11, 32'h8000, 32'h0001, 1'b1);
    wait_ov0();
    dchk("sbb", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      ra = $urandom;
      rb = $urandom;
      case (i % 8)
        0: ra = 32'h0;
        1: ra = 32'hFFFF_FFFF;
        2: rb = ~ra;
        3: rb = ra;
        4: begin ra = 32'h8000_8000; rb = 32'h0000_8000; end
        default: ;
      endcase
      issue(2'($urandom), ra, rb, 1'($urandom));
      drain(1'b1);
    end
    drain(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
